// File: rtl/cpu_pkg.sv
// Shared CPU constants and types.
// Used by the fetch stage and the decode controller.
package cpu_pkg;

  localparam logic [5:0]  OPCODE_HALT = 6'h3f;
  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH,
    DRAIN,
    HALT
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } if_id_t;

  function automatic logic is_halt(
    input logic [31:0] w
  );
    return w[31:26] == OPCODE_HALT;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched word
// that arrived while decode was stalled.
module fetch_skid_buf
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   unload,
  input  logic   clear,
  input  if_id_t din,
  output if_id_t dout,
  output logic   full
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      dout <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      dout <= din;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem req/ack FSM
// and the IF/ID pipeline register.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        halted
);

  fetch_state_t state_q;
  logic [31:0]  pc_q;
  logic [31:0]  tgt_q;
  if_id_t       ifid_q;
  logic         valid_q;

  logic         buf_full;
  if_id_t       buf_dout;
  if_id_t       fetched;
  logic [31:0]  pc_plus4;
  logic         accept;
  logic         f_acc;
  logic         d_acc;

  // rst gates req so it drops the instant reset hits
  assign imem_req = ~rst & ((state_q == DRAIN) |
                    ((state_q == FETCH) & ~buf_full));
  assign imem_addr = pc_q;

  assign accept   = imem_req & imem_ack;
  assign f_acc    = accept & (state_q == FETCH);
  assign d_acc    = accept & (state_q == DRAIN);
  assign pc_plus4 = pc_q + 32'd4;
  assign fetched  = '{instr: imem_rdata, pc4: pc_plus4};

  fetch_skid_buf u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (~redirect & stall & f_acc),
    .unload (~redirect & ~stall & buf_full),
    .clear  (redirect),
    .din    (fetched),
    .dout   (buf_dout),
    .full   (buf_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      ifid_q  <= '{instr: NOP_INSTR, pc4: 32'd0};
      valid_q <= 1'b0;
    end else if (redirect) begin
      valid_q      <= 1'b0;
      ifid_q.instr <= NOP_INSTR;
      if (imem_req & ~imem_ack) begin
        state_q <= DRAIN;
        tgt_q   <= redirect_pc;
      end else begin
        state_q <= FETCH;
        pc_q    <= redirect_pc;
      end
    end else begin
      if (f_acc) begin
        pc_q <= pc_plus4;
        if (is_halt(imem_rdata))
          state_q <= HALT;
      end
      if (d_acc) begin
        pc_q    <= tgt_q;
        state_q <= FETCH;
      end
      unique case (1'b1)
        stall: ;
        ~stall & buf_full: begin
          ifid_q  <= buf_dout;
          valid_q <= 1'b1;
        end
        ~stall & ~buf_full & f_acc: begin
          ifid_q  <= fetched;
          valid_q <= 1'b1;
        end
        default: begin
          ifid_q.instr <= NOP_INSTR;
          valid_q      <= 1'b0;
        end
      endcase
    end
  end

  assign if_id_instr = ifid_q.instr;
  assign if_id_pc4   = ifid_q.pc4;
  assign if_id_valid = valid_q;
  assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: memory model
// with programmable ack latency plus IF/ID monitor.
module tb_fetch_stage;
  import cpu_pkg::*;

  localparam logic [31:0] W_ADD  = 32'h0020_81B3;
  localparam logic [31:0] W_SLT  = 32'h0020_A233;
  localparam logic [31:0] W_LW   = 32'h0000_A283;
  localparam logic [31:0] W_HALT = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'hDEAD_BEEF;
  logic        imem_ack = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        halted;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ack    (imem_ack),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_id_instr (if_id_instr),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid),
    .halted      (halted)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem[256];
  int          delay = 0;
  int          cnt = 0;
  bit          waiting = 0;
  logic [31:0] wait_addr = '0;
  logic        last_stall = 1'b0;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_i(logic [31:0] i, logic [31:0] p);
    exp_t e;
    e.instr = i;
    e.pc4   = p;
    exp_q.push_back(e);
  endtask

  // memory model: evaluated just after each falling edge
  always begin
    @(negedge clk);
    #1;
    if (imem_req) begin
      if (waiting)
        check("addr_stable", imem_addr, wait_addr);
      if (cnt == delay) begin
        imem_ack   = 1'b1;
        imem_rdata = mem[imem_addr[9:2]];
        cnt        = 0;
        waiting    = 0;
        if (addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL req_addr: got %h expected none", imem_addr);
        end else begin
          check("req_addr", imem_addr, addr_q.pop_front());
        end
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        cnt++;
        waiting   = 1;
        wait_addr = imem_addr;
      end
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      cnt        = 0;
      waiting    = 0;
    end
  end

  always @(posedge clk) last_stall <= stall;

  // IF/ID monitor: a valid word after a non-stall edge is new
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (if_id_valid && !last_stall) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ifid_extra: got %h expected none", if_id_instr);
      end else begin
        e = exp_q.pop_front();
        check("ifid_instr", if_id_instr, e.instr);
        check("ifid_pc4", if_id_pc4, e.pc4);
      end
    end
  end

  task automatic start_test(int d);
    @(negedge clk);
    rst         = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    delay       = d;
    for (int i = 0; i < 256; i++)
      mem[i] = 32'h13 | (i << 7);
    exp_q.delete();
    addr_q.delete();
    @(negedge clk);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic finish_test(string name);
    int i;
    for (i = 0; i < 200 && !halted; i++)
      @(negedge clk);
    checks++;
    if (!halted) begin
      errors++;
      $display("FAIL %s_timeout: got halted=0 expected 1", name);
    end
    repeat (3) @(negedge clk);
    check({name, "_req"}, 32'(imem_req), 0);
    check({name, "_ifid_left"}, 32'(exp_q.size()), 0);
    check({name, "_addr_left"}, 32'(addr_q.size()), 0);
  endtask

  initial begin
    // t1: back-to-back same-cycle acks
    start_test(0);
    check("rst_req", 32'(imem_req), 0);
    check("rst_valid", 32'(if_id_valid), 0);
    check("rst_pc4", if_id_pc4, 0);
    check("rst_instr", if_id_instr, 0);
    check("rst_halted", 32'(halted), 0);
    mem[0] = W_ADD; mem[1] = W_SLT; mem[2] = W_LW; mem[3] = W_HALT;
    addr_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    push_i(W_ADD, 4); push_i(W_SLT, 8);
    push_i(W_LW, 12); push_i(W_HALT, 16);
    release_rst();
    @(negedge clk);
    check("t1_valid_c1", 32'(if_id_valid), 1);
    check("t1_addr_c1", imem_addr, 32'h4);
    finish_test("t1");

    // t2: ack 3 cycles after req
    start_test(3);
    mem[0] = W_ADD; mem[1] = W_SLT; mem[2] = W_HALT;
    addr_q = '{32'h0, 32'h4, 32'h8};
    push_i(W_ADD, 4); push_i(W_SLT, 8); push_i(W_HALT, 12);
    release_rst();
    repeat (5) @(negedge clk);
    check("t2_gap_valid", 32'(if_id_valid), 0);
    check("t2_gap_addr", imem_addr, 32'h4);
    finish_test("t2");

    // t3: stall while word at 0x8 acks
    start_test(0);
    mem[0] = W_ADD; mem[1] = W_SLT; mem[2] = W_LW;
    mem[3] = W_ADD; mem[4] = W_HALT;
    addr_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    push_i(W_ADD, 4); push_i(W_SLT, 8); push_i(W_LW, 12);
    push_i(W_ADD, 16); push_i(W_HALT, 20);
    release_rst();
    @(negedge clk);
    @(negedge clk);
    stall = 1'b1;
    @(negedge clk);
    check("t3_full_req", 32'(imem_req), 0);
    check("t3_hold_pc4", if_id_pc4, 8);
    check("t3_hold_valid", 32'(if_id_valid), 1);
    @(negedge clk);
    @(negedge clk);
    check("t3_full_req2", 32'(imem_req), 0);
    stall = 1'b0;
    @(negedge clk);
    check("t3_rel_pc4", if_id_pc4, 12);
    check("t3_rel_instr", if_id_instr, W_LW);
    check("t3_rel_req", 32'(imem_req), 1);
    check("t3_rel_addr", imem_addr, 32'hC);
    finish_test("t3");

    // t4: redirect with request outstanding
    start_test(2);
    mem[0] = W_ADD; mem[16] = W_SLT; mem[17] = W_HALT;
    addr_q = '{32'h0, 32'h4, 32'h40, 32'h44};
    push_i(W_ADD, 4); push_i(W_SLT, 32'h44);
    push_i(W_HALT, 32'h48);
    release_rst();
    repeat (3) @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    @(negedge clk);
    redirect    = 1'b0;
    redirect_pc = '0;
    check("t4_drain_addr", imem_addr, 32'h4);
    check("t4_drain_req", 32'(imem_req), 1);
    check("t4_flush_valid", 32'(if_id_valid), 0);
    @(negedge clk);
    @(negedge clk);
    check("t4_new_addr", imem_addr, 32'h40);
    finish_test("t4");

    // t5: redirect coincides with ack
    start_test(0);
    mem[0] = W_ADD; mem[1] = W_LW; mem[32] = W_SLT; mem[33] = W_HALT;
    addr_q = '{32'h0, 32'h4, 32'h80, 32'h84};
    push_i(W_ADD, 4); push_i(W_SLT, 32'h84);
    push_i(W_HALT, 32'h88);
    release_rst();
    @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 32'h80;
    @(negedge clk);
    redirect    = 1'b0;
    redirect_pc = '0;
    check("t5_addr", imem_addr, 32'h80);
    check("t5_valid", 32'(if_id_valid), 0);
    check("t5_req", 32'(imem_req), 1);
    finish_test("t5");

    // t6: halt, redirect out of halt, reset mid-wait
    start_test(0);
    mem[0] = W_HALT;
    addr_q = '{32'h0};
    push_i(W_HALT, 4);
    release_rst();
    @(negedge clk);
    check("t6_halted", 32'(halted), 1);
    check("t6_halt_req", 32'(imem_req), 0);
    check("t6_halt_instr", if_id_instr, W_HALT);
    @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    delay       = 3;
    @(negedge clk);
    redirect    = 1'b0;
    redirect_pc = '0;
    check("t6_unhalt", 32'(halted), 0);
    check("t6_unhalt_req", 32'(imem_req), 1);
    check("t6_unhalt_addr", imem_addr, 32'h100);
    @(negedge clk);
    rst = 1'b1;
    #4;
    check("t6_rst_req", 32'(imem_req), 0);
    check("t6_rst_addr", imem_addr, 0);
    check("t6_rst_valid", 32'(if_id_valid), 0);
    check("t6_rst_instr", if_id_instr, 0);
    check("t6_rst_pc4", if_id_pc4, 0);
    check("t6_rst_halted", 32'(halted), 0);
    repeat (3) @(negedge clk);
    check("t6_ifid_left", 32'(exp_q.size()), 0);
    check("t6_addr_left", 32'(addr_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
